// File: rtl/tt_result_uart_tx.sv
// rtl/tt_result_uart_tx.sv - serial frame transmitter for the 8-bit datapath result
//
// Takes one result byte per valid/ready handshake and sends it as an
// asynchronous frame: start bit, D0..D7 (LSB first), optional even-parity bit,
// then one or two stop bits. The line idles high.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        enable; only gates acceptance of a new byte
//   data_in    byte to send, captured on the accept edge
//   valid_in   data_in is valid
//   ready_out  a byte can be accepted this cycle
//   tx         serial line output (idle high)
//   busy       a frame is in progress
//   frame_done one-cycle pulse in the first idle cycle after a frame
module tt_result_uart_tx #(
    parameter int CLK_DIV   = 16,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic             stop_idx, stop_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             parity, parity_n;
    logic             tx_n;
    logic             frame_done_n;
    logic             armed;
    logic             bit_end;
    logic             accept;

    // armed keeps ready_out low while reset is held and until the first edge
    // after release, even though state already reads IDLE during reset.
    assign bit_end   = (baud_cnt == CNT_W'(CLK_DIV - 1));
    assign ready_out = (state == S_IDLE) && ena && armed;
    assign accept    = ready_out && valid_in;

    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_idx_n    = bit_idx;
        stop_idx_n   = stop_idx;
        shreg_n      = shreg;
        parity_n     = parity;
        frame_done_n = 1'b0;

        if (state != S_IDLE) begin
            baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n    = S_START;
                    shreg_n    = data_in;
                    parity_n   = ^data_in;
                    bit_idx_n  = 3'd0;
                    stop_idx_n = 1'b0;
                    baud_cnt_n = '0;
                end
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        state_n      = S_IDLE;
                        frame_done_n = 1'b1;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // tx is registered, so it is derived from where the FSM is going;
        // shreg_n[0] is the data bit that will be on the line next cycle.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = parity_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            stop_idx   <= 1'b0;
            shreg      <= 8'd0;
            parity     <= 1'b0;
            armed      <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            shreg      <= shreg_n;
            parity     <= parity_n;
            armed      <= 1'b1;
            tx         <= tx_n;
            busy       <= (state_n != S_IDLE);
            frame_done <= frame_done_n;
        end
    end

endmodule
